// File: rtl/microcode_store_if.sv
// Bootstrap byte-stream handshake between the loader (master) and the
// microcode store (slave).
interface microcode_store_if;
    logic [7:0] BOOTSTRAP_DATA;
    logic       BOOTSTRAP_VALID;
    logic       BOOTSTRAP_READY;

    modport master (
        output BOOTSTRAP_DATA,
        output BOOTSTRAP_VALID,
        input  BOOTSTRAP_READY
    );

    modport slave (
        input  BOOTSTRAP_DATA,
        input  BOOTSTRAP_VALID,
        output BOOTSTRAP_READY
    );
endinterface

// File: rtl/microcode_store.sv
// Writable microcode control store: loads a little-endian byte image with an
// optional XOR checksum, then serves registered lookups on {cond, opcode, uop}.
module microcode_store #(
    parameter int unsigned COND_BITS   = 1,
    parameter int unsigned OPCODE_BITS = 6,
    parameter int unsigned UOP_BITS    = 5,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CHECKSUM    = 1
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [COND_BITS+OPCODE_BITS+UOP_BITS-1:0] ADDR,
    output logic [WIDTH-1:0]                          OUT,
    microcode_store_if.slave                          boot,
    output logic                                      N_BOOTED,
    output logic                                      BOOT_ERR
);
    localparam int unsigned ADDR_BITS = COND_BITS + OPCODE_BITS + UOP_BITS;
    localparam int unsigned ENTRIES   = 1 << ADDR_BITS;
    localparam int unsigned BYTES     = WIDTH / 8;
    localparam int unsigned IDX_BITS  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(BYTES - 1);
    localparam logic [ADDR_BITS:0]   LAST_WORD = (ADDR_BITS + 1)'(ENTRIES - 1);

    typedef enum logic [1:0] {S_LOAD, S_CHECK, S_RUN, S_ERROR} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS:0]   word_addr_q, word_addr_d;
    logic [IDX_BITS-1:0]  byte_idx_q, byte_idx_d;
    logic [WIDTH-1:0]     partial_q, partial_d, word_w;
    logic [7:0]           sum_q, sum_d;
    logic                 ready_q, ready_d;
    logic                 n_booted_q, n_booted_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [WIDTH-1:0]     mem_q [ENTRIES];
    logic                 accept, last_byte, wr_en;

    // ready_q is high exactly in LOAD/CHECK, so it doubles as the state gate
    assign accept    = boot.BOOTSTRAP_VALID & ready_q;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign wr_en     = accept && (state_q == S_LOAD) && last_byte;

    assign boot.BOOTSTRAP_READY = ready_q;
    assign N_BOOTED             = n_booted_q;
    assign BOOT_ERR             = err_q;
    assign OUT                  = out_q;

    always_comb begin
        word_w = partial_q;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (byte_idx_q == IDX_BITS'(b)) begin
                word_w[8*b +: 8] = boot.BOOTSTRAP_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_LOAD;
            ready_q    <= 1'b1;
            n_booted_q <= 1'b1;
            err_q      <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            n_booted_q <= n_booted_d;
            err_q      <= err_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: begin
                if (wr_en && (word_addr_q == LAST_WORD)) begin
                    state_d = (CHECKSUM != 0) ? S_CHECK : S_RUN;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (boot.BOOTSTRAP_DATA == sum_q) ? S_RUN : S_ERROR;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Status outputs follow the next state so they switch on the same edge
    always_comb begin
        ready_d    = (state_d == S_LOAD) || (state_d == S_CHECK);
        n_booted_d = (state_d != S_RUN);
        err_d      = (state_d == S_ERROR);
        out_d      = (state_q == S_RUN) ? mem_q[ADDR] : '0;
    end

    always_comb begin
        word_addr_d = word_addr_q;
        byte_idx_d  = byte_idx_q;
        partial_d   = partial_q;
        sum_d       = sum_q;
        if (accept && (state_q == S_LOAD)) begin
            sum_d = sum_q ^ boot.BOOTSTRAP_DATA;
            if (last_byte) begin
                word_addr_d = word_addr_q + (ADDR_BITS + 1)'(1);
                byte_idx_d  = '0;
                partial_d   = '0;
            end else begin
                byte_idx_d  = byte_idx_q + IDX_BITS'(1);
                partial_d   = word_w;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_addr_q <= '0;
            byte_idx_q  <= '0;
            partial_q   <= '0;
            sum_q       <= '0;
        end else begin
            word_addr_q <= word_addr_d;
            byte_idx_q  <= byte_idx_d;
            partial_q   <= partial_d;
            sum_q       <= sum_d;
        end
    end

    // Store is deliberately not reset; every load rewrites all entries
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[word_addr_q[ADDR_BITS-1:0]] <= word_w;
        end
    end
endmodule

// File: tb/tb_microcode_store.sv
// Scoreboard bench for microcode_store: small 8x16 checksummed store plus a
// default-sized 4096x32 store without checksum.
module tb_microcode_store;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST0, RST1;
    logic [2:0]  addr0;
    logic [15:0] out0;
    logic        nb0, err0;
    logic [11:0] addr1;
    logic [31:0] out1;
    logic        nb1, err1;

    microcode_store_if bs0 ();
    microcode_store_if bs1 ();

    microcode_store #(
        .COND_BITS(1), .OPCODE_BITS(1), .UOP_BITS(1), .WIDTH(16), .CHECKSUM(1)
    ) dut0 (
        .CLK(CLK), .RST(RST0), .ADDR(addr0), .OUT(out0),
        .boot(bs0.slave), .N_BOOTED(nb0), .BOOT_ERR(err0)
    );

    microcode_store #(
        .CHECKSUM(0)
    ) dut1 (
        .CLK(CLK), .RST(RST1), .ADDR(addr1), .OUT(out1),
        .boot(bs1.slave), .N_BOOTED(nb1), .BOOT_ERR(err1)
    );

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    logic [15:0] img [8];
    logic [31:0] big [4096];
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset0();
        RST0 = 1'b1;
        #3;
        RST0 = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] img_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) s = s ^ img[i][7:0] ^ img[i][15:8];
        return s;
    endfunction

    task automatic send0(input logic [7:0] b, input int unsigned max_gap);
        bs0.BOOTSTRAP_VALID = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
        bs0.BOOTSTRAP_DATA  = b;
        bs0.BOOTSTRAP_VALID = 1'b1;
        tick();
        bs0.BOOTSTRAP_VALID = 1'b0;
    endtask

    // Streams img low byte first, then the given checksum byte.
    task automatic load0(input logic [7:0] csum, input int unsigned max_gap);
        for (int i = 0; i < 8; i++) begin
            send0(img[i][7:0], max_gap);
            send0(img[i][15:8], max_gap);
        end
        check("nb_before_csum", 32'(nb0), 32'd1);
        check("rdy_before_csum", 32'(bs0.BOOTSTRAP_READY), 32'd1);
        send0(csum, max_gap);
    endtask

    task automatic lookup0(input logic [2:0] a);
        addr0 = a;
        sb_q.push_back({16'h0, img[a]});
        tick();
        check($sformatf("lookup0_%0d", a), 32'(out0), sb_q.pop_front());
    endtask

    task automatic sweep0();
        for (int i = 0; i < 8; i++) lookup0(3'(i));
    endtask

    initial begin
        RST0 = 1'b1;
        RST1 = 1'b1;
        addr0 = '0;
        addr1 = '0;
        bs0.BOOTSTRAP_DATA = '0; bs0.BOOTSTRAP_VALID = 1'b0;
        bs1.BOOTSTRAP_DATA = '0; bs1.BOOTSTRAP_VALID = 1'b0;
        #3;
        check("rst_out0", 32'(out0), 32'd0);
        check("rst_rdy0", 32'(bs0.BOOTSTRAP_READY), 32'd1);
        check("rst_nb0", 32'(nb0), 32'd1);
        check("rst_err0", 32'(err0), 32'd0);
        check("rst_nb1", 32'(nb1), 32'd1);
        check("rst_rdy1", 32'(bs1.BOOTSTRAP_READY), 32'd1);
        #4;
        RST0 = 1'b0;
        tick();

        // Scenario 2: plain image, correct checksum, back-to-back bytes
        for (int i = 0; i < 8; i++) img[i] = {8'hA0 + 8'(i), 8'h10 + 8'(i)};
        load0(8'h00, 0);
        check("nb_after_17", 32'(nb0), 32'd0);
        check("err_after_17", 32'(err0), 32'd0);
        check("rdy_in_run", 32'(bs0.BOOTSTRAP_READY), 32'd0);
        check("out_at_boot_edge", 32'(out0), 32'd0);
        lookup0(3'd5);
        lookup0(3'd0);
        lookup0(3'd7);

        // Scenario 1: asynchronous reset mid-cycle while OUT is nonzero
        #3;
        RST0 = 1'b1;
        #1;
        check("arst_out", 32'(out0), 32'd0);
        check("arst_rdy", 32'(bs0.BOOTSTRAP_READY), 32'd1);
        check("arst_nb", 32'(nb0), 32'd1);
        check("arst_err", 32'(err0), 32'd0);
        #1;
        RST0 = 1'b0;
        tick();

        // Scenario 3: bad checksum, then hammer with bytes
        load0(8'h01, 0);
        for (int c = 0; c < 100; c++) begin
            bs0.BOOTSTRAP_VALID = 1'b1;
            bs0.BOOTSTRAP_DATA  = 8'($urandom);
            addr0 = 3'($urandom);
            if (c % 10 == 0) begin
                check("err_sticky", 32'(err0), 32'd1);
                check("err_nb", 32'(nb0), 32'd1);
                check("err_rdy", 32'(bs0.BOOTSTRAP_READY), 32'd0);
                check("err_out", 32'(out0), 32'd0);
            end
            tick();
        end
        bs0.BOOTSTRAP_VALID = 1'b0;
        check("err_sticky_end", 32'(err0), 32'd1);
        check("err_out_end", 32'(out0), 32'd0);

        // Scenario 4: same image with random idle gaps, then junk in RUN
        reset0();
        load0(img_sum(), 3);
        check("gap_nb", 32'(nb0), 32'd0);
        for (int c = 0; c < 20; c++) begin
            check("run_rdy", 32'(bs0.BOOTSTRAP_READY), 32'd0);
            bs0.BOOTSTRAP_VALID = 1'b1;
            bs0.BOOTSTRAP_DATA  = 8'($urandom);
            tick();
        end
        bs0.BOOTSTRAP_VALID = 1'b0;
        sweep0();

        // Scenario 5: aborted partial load, then a fresh image
        reset0();
        for (int i = 0; i < 7; i++) send0(8'hE0 + 8'(i), 0);
        reset0();
        for (int i = 0; i < 8; i++) img[i] = {8'h5A + 8'(i), 8'hC3};
        load0(img_sum(), 1);
        check("reload_nb", 32'(nb0), 32'd0);
        lookup0(3'd3);
        sweep0();

        // Scenario 6: default widths, no checksum
        for (int i = 0; i < 4096; i++) big[i] = $urandom;
        #3;
        RST1 = 1'b0;
        tick();
        for (int k = 0; k < 16384; k++) begin
            bs1.BOOTSTRAP_DATA  = big[k / 4][8*(k % 4) +: 8];
            bs1.BOOTSTRAP_VALID = 1'b1;
            tick();
            if (k == 16382) check("big_nb_before_last", 32'(nb1), 32'd1);
            if (k == 16383) check("big_nb_on_last", 32'(nb1), 32'd0);
        end
        bs1.BOOTSTRAP_VALID = 1'b0;
        check("big_rdy_run", 32'(bs1.BOOTSTRAP_READY), 32'd0);
        check("big_err", 32'(err1), 32'd0);
        for (int i = 0; i < 4096; i++) begin
            addr1 = 12'(i);
            sb_q.push_back(big[i]);
            tick();
            check("big_lookup", out1, sb_q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
